// File: rtl/fetch_ctrl_if.sv
// rtl/fetch_ctrl_if.sv - loader, imem and decode signals of the fetch sequencer
interface fetch_ctrl_if #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int DATA_BYTES = 4
);
  logic                  ld_valid_i;
  logic                  ld_ready_o;
  logic [31:0]           ld_addr_i;
  logic [DATA_WIDTH-1:0] ld_wdata_i;
  logic [DATA_BYTES-1:0] ld_be_i;
  logic                  ld_done_i;
  logic                  br_taken_i;
  logic [31:0]           br_target_i;
  logic                  stall_i;
  logic [ADDR_WIDTH-1:0] imem_addr_o;
  logic [DATA_WIDTH-1:0] imem_wdata_o;
  logic [DATA_BYTES-1:0] imem_wen_o;
  logic [DATA_WIDTH-1:0] imem_rdata_i;
  logic [31:0]           instr_o;
  logic [31:0]           pc_o;
  logic                  instr_valid_o;

  modport master (
    input  ld_valid_i, ld_addr_i, ld_wdata_i, ld_be_i, ld_done_i,
    input  br_taken_i, br_target_i, stall_i, imem_rdata_i,
    output ld_ready_o, imem_addr_o, imem_wdata_o, imem_wen_o,
    output instr_o, pc_o, instr_valid_o
  );

  modport slave (
    output ld_valid_i, ld_addr_i, ld_wdata_i, ld_be_i, ld_done_i,
    output br_taken_i, br_target_i, stall_i, imem_rdata_i,
    input  ld_ready_o, imem_addr_o, imem_wdata_o, imem_wen_o,
    input  instr_o, pc_o, instr_valid_o
  );
endinterface

// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - imem port owner: boot-load window, then sequential fetch with stall/redirect
module fetch_ctrl #(
  parameter int          ADDR_WIDTH = 10,
  parameter int          DATA_WIDTH = 32,
  parameter int          DATA_BYTES = 4,
  parameter logic [31:0] RESET_PC   = 32'h100,
  parameter bit          BOOT_LOAD  = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  fetch_ctrl_if.master  bus
);
  typedef enum logic [1:0] {LOAD, PRIME, FETCH} state_t;

  localparam state_t RST_STATE = BOOT_LOAD ? LOAD : PRIME;

  state_t      state_q, state_d;
  logic [31:0] iss_pc_q;
  logic [31:0] nxt_pc;
  logic        rsp_vld_q;
  logic        unused_bits;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= RST_STATE;
      iss_pc_q  <= RESET_PC;
      rsp_vld_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q != LOAD) begin
        iss_pc_q  <= nxt_pc;
        rsp_vld_q <= 1'b1;
      end
    end
  end

  // Redirect beats stall; PRIME always issues RESET_PC unless redirected.
  always_comb begin
    nxt_pc = iss_pc_q + 32'd4;
    if (bus.br_taken_i)
      nxt_pc = {bus.br_target_i[31:2], 2'b00};
    else if (state_q == PRIME)
      nxt_pc = RESET_PC;
    else if (bus.stall_i)
      nxt_pc = iss_pc_q;
  end

  always_comb begin
    state_d          = state_q;
    bus.imem_addr_o  = nxt_pc[ADDR_WIDTH+1:2];
    bus.imem_wdata_o = bus.ld_wdata_i;
    bus.imem_wen_o   = '0;
    bus.ld_ready_o   = 1'b0;
    case (state_q)
      LOAD: begin
        bus.imem_addr_o = bus.ld_addr_i[ADDR_WIDTH+1:2];
        bus.imem_wen_o  = bus.ld_valid_i ? bus.ld_be_i : '0;
        bus.ld_ready_o  = 1'b1;
        if (bus.ld_done_i)
          state_d = PRIME;
      end
      PRIME:   state_d = FETCH;
      default: state_d = FETCH;
    endcase
  end

  // The word being returned this cycle is squashed when a redirect is taken.
  assign bus.pc_o          = iss_pc_q;
  assign bus.instr_o       = bus.imem_rdata_i;
  assign bus.instr_valid_o = (state_q == FETCH) && rsp_vld_q && !bus.br_taken_i;

  assign unused_bits = ^{bus.ld_addr_i[31:ADDR_WIDTH+2], bus.ld_addr_i[1:0],
                         bus.br_target_i[1:0]};
endmodule
